// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte stream bundle for uart_tx_arbiter.
// The requesters drive valid/data/last as the master; the arbiter returns
// per-requester ready as the slave.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;

  modport master (output req_valid, output req_data, output req_last, input req_ready);
  modport slave  (input req_valid, input req_data, input req_last, output req_ready);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ byte streams.
// Round-robin grant per packet, fixed settle gap after every write strobe,
// and grant revocation when the owner holds valid low for STALL_MAX cycles.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int GAP       = 15,
  parameter int STALL_MAX = 1023
) (
  input  logic               clk_50_mhz,
  input  logic               rst,
  uart_tx_arbiter_if.slave   req,
  output logic [7:0]         uart_din,
  output logic               uart_wr_en,
  input  logic               uart_tx_busy,
  output logic [N_REQ-1:0]   grant,
  output logic               active,
  output logic               stall_err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int STL_W = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP);
  localparam logic [STL_W-1:0] STALL_TOP = STL_W'(STALL_MAX - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] g_q, g_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             active_q, active_d;
  logic [7:0]       din_q, din_d;
  logic             wr_en_q, wr_en_d;
  logic             stall_err_q, stall_err_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [STL_W-1:0] stall_q, stall_d;

  logic [IDX_W-1:0] ptr;
  logic [N_REQ-1:0] rot;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] arb_idx;
  logic             sel_valid, sel_last;
  logic [7:0]       sel_data;
  logic             can_send, accept;
  logic [N_REQ-1:0] ready_vec;

  // Search starts one past the last owner so every requester gets a turn.
  assign ptr = (last_q == LAST_IDX) ? '0 : last_q + IDX_W'(1);

  // Rotate valid by ptr, take the lowest set bit, then map back to an index.
  always_comb begin
    rot     = N_REQ'({req.req_valid, req.req_valid} >> ptr);
    sum     = '0;
    arb_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) sum = {1'b0, ptr} + (IDX_W + 1)'(k);
    end
    if (sum >= (IDX_W + 1)'(N_REQ)) sum = sum - (IDX_W + 1)'(N_REQ);
    arb_idx = sum[IDX_W-1:0];
  end

  // Pick out the current owner's stream and build the ready vector.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    ready_vec = '0;
    can_send  = (state_q == ST_SEND) && (gap_q == '0) && !uart_tx_busy;
    for (int i = 0; i < N_REQ; i++) begin
      if (g_q == IDX_W'(i)) begin
        sel_valid    = req.req_valid[i];
        sel_last     = req.req_last[i];
        sel_data     = req.req_data[8*i +: 8];
        ready_vec[i] = can_send;
      end
    end
    accept = can_send && sel_valid;
  end

  assign req.req_ready = ready_vec;

  // Next-state logic for arbitration, byte transfer, gap pacing and stall watch.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d     = state_q;
    g_d         = g_q;
    last_d      = last_q;
    grant_d     = grant_q;
    active_d    = active_q;
    din_d       = din_q;
    wr_en_d     = 1'b0;
    stall_err_d = 1'b0;
    stall_d     = stall_q;
    gap_d       = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;

    case (state_q)
      ST_IDLE: begin
        stall_d = '0;
        if (|req.req_valid) begin
          g_d      = arb_idx;
          active_d = 1'b1;
          state_d  = ST_SEND;
          for (int i = 0; i < N_REQ; i++) grant_d[i] = (arb_idx == IDX_W'(i));
        end
      end
      default: begin
        if (accept) begin
          din_d   = sel_data;
          wr_en_d = 1'b1;
          gap_d   = GAP_LOAD;
          stall_d = '0;
          if (sel_last) begin
            state_d  = ST_IDLE;
            last_d   = g_q;
            grant_d  = '0;
            active_d = 1'b0;
          end
        end else if (!sel_valid) begin
          // Only a missing byte counts as a stall; gap or busy backpressure does not.
          if (stall_q == STALL_TOP) begin
            stall_err_d = 1'b1;
            state_d     = ST_IDLE;
            last_d      = g_q;
            grant_d     = '0;
            active_d    = 1'b0;
            stall_d     = '0;
          end else begin
            stall_d = stall_q + STL_W'(1);
          end
        end
      end
    endcase
  end

  // State register with synchronous reset; reset also drops a pending strobe.
  always_ff @(posedge clk_50_mhz) begin
    // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= ST_IDLE;
      g_q         <= '0;
      last_q      <= LAST_IDX;
      grant_q     <= '0;
      active_q    <= 1'b0;
      din_q       <= 8'h00;
      wr_en_q     <= 1'b0;
      stall_err_q <= 1'b0;
      gap_q       <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      active_q    <= active_d;
      din_q       <= din_d;
      wr_en_q     <= wr_en_d;
      stall_err_q <= stall_err_d;
      gap_q       <= gap_d;
      stall_q     <= stall_d;
    end
  end

  assign uart_din   = din_q;
  assign uart_wr_en = wr_en_q;
  assign grant      = grant_q;
  assign active     = active_q;
  assign stall_err  = stall_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: dut_a uses the default parameters,
// dut_b uses GAP=2, STALL_MAX=4 for the short-pause stall boundary.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       busy_a, busy_b;
  logic [7:0] din_a, din_b;
  logic       wr_en_a, wr_en_b;
  logic [3:0] grant_a, grant_b;
  logic       active_a, active_b;
  logic       stall_a, stall_b;

  uart_tx_arbiter_if #(.N_REQ(4)) ifa ();
  uart_tx_arbiter_if #(.N_REQ(4)) ifb ();

  uart_tx_arbiter #(.N_REQ(4)) dut_a (
    .clk_50_mhz(clk), .rst(rst), .req(ifa),
    .uart_din(din_a), .uart_wr_en(wr_en_a), .uart_tx_busy(busy_a),
    .grant(grant_a), .active(active_a), .stall_err(stall_a)
  );

  uart_tx_arbiter #(.N_REQ(4), .GAP(2), .STALL_MAX(4)) dut_b (
    .clk_50_mhz(clk), .rst(rst), .req(ifb),
    .uart_din(din_b), .uart_wr_en(wr_en_b), .uart_tx_busy(busy_b),
    .grant(grant_b), .active(active_b), .stall_err(stall_b)
  );

  // Per-instance, per-requester byte sources.
  logic [7:0] s_byte [2][4][8];
  bit         s_last [2][4][8];
  int         s_len  [2][4];
  int         s_pos  [2][4];
  int         s_pause[2][4];
  int         s_hold [2][4];
  bit         s_acc  [2][4];

  int         cyc;
  int         wr_cyc_a[$], wr_cyc_b[$];
  logic [7:0] wr_dat_a[$], wr_dat_b[$];
  int         stall_cyc_a[$], stall_cyc_b[$];
  logic [3:0] stall_grant_a;
  int         acc_cnt_a;
  int         grant_viol, ready_viol;
  bit         gchk_en;
  logic [3:0] gchk_val;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bit va, vb;
      va = (s_pos[0][i] < s_len[0][i]) && (s_hold[0][i] == 0);
      vb = (s_pos[1][i] < s_len[1][i]) && (s_hold[1][i] == 0);
      ifa.req_valid[i]      = va;
      ifa.req_data[8*i +: 8] = va ? s_byte[0][i][s_pos[0][i]] : 8'h00;
      ifa.req_last[i]       = va ? s_last[0][i][s_pos[0][i]] : 1'b0;
      ifb.req_valid[i]      = vb;
      ifb.req_data[8*i +: 8] = vb ? s_byte[1][i][s_pos[1][i]] : 8'h00;
      ifb.req_last[i]       = vb ? s_last[1][i][s_pos[1][i]] : 1'b0;
    end
  endtask

  // One clock: observe at the falling edge, advance sources just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      s_acc[0][i] = ifa.req_valid[i] && ifa.req_ready[i];
      s_acc[1][i] = ifb.req_valid[i] && ifb.req_ready[i];
      if (s_acc[0][i]) acc_cnt_a++;
    end
    if (wr_en_a) begin wr_cyc_a.push_back(cyc); wr_dat_a.push_back(din_a); end
    if (wr_en_b) begin wr_cyc_b.push_back(cyc); wr_dat_b.push_back(din_b); end
    if (stall_a) begin stall_cyc_a.push_back(cyc); stall_grant_a = grant_a; end
    if (stall_b) stall_cyc_b.push_back(cyc);
    if (gchk_en && active_a && grant_a != gchk_val) grant_viol++;
    if (busy_a && ifa.req_ready != 4'b0000) ready_viol++;
    @(posedge clk);
    cyc++;
    #1;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (s_acc[n][i]) begin
          s_pos[n][i]++;
          s_hold[n][i] = s_pause[n][i];
        end else if (s_hold[n][i] > 0) begin
          s_hold[n][i]--;
        end
      end
    end
    drive();
  endtask

  task automatic clear_sources();
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < 4; i++) begin
        s_len[n][i] = 0; s_pos[n][i] = 0; s_pause[n][i] = 0; s_hold[n][i] = 0;
        s_acc[n][i] = 1'b0;
        for (int p = 0; p < 8; p++) begin s_byte[n][i][p] = 8'h00; s_last[n][i][p] = 1'b0; end
      end
  endtask

  task automatic do_reset();
    clear_sources();
    busy_a = 1'b0; busy_b = 1'b0;
    drive();
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    wr_cyc_a.delete(); wr_dat_a.delete(); wr_cyc_b.delete(); wr_dat_b.delete();
    stall_cyc_a.delete(); stall_cyc_b.delete();
    acc_cnt_a = 0; grant_viol = 0; ready_viol = 0; gchk_en = 1'b0; gchk_val = 4'b0000;
    stall_grant_a = 4'hx;
  endtask

  // Wait for n strobes (and optionally for active to drop); the count is the timeout check.
  task automatic wait_wr(input bit inst_b, input int n, input bit need_idle, input int bound,
                         input string tag);
    for (int c = 0; c < bound; c++) begin
      if (inst_b ? (wr_dat_b.size() >= n && (!need_idle || !active_b))
                 : (wr_dat_a.size() >= n && (!need_idle || !active_a))) break;
      cycle();
    end
    check(tag, inst_b ? wr_dat_b.size() : wr_dat_a.size(), n);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    logic [7:0] exp_rr [12];
    cyc = 0;
    rst = 1'b1;
    clear_sources();
    busy_a = 1'b0; busy_b = 1'b0;
    drive();

    // Reset state.
    do_reset();
    check("rst_grant",  grant_a, 4'b0000);
    check("rst_active", active_a, 1'b0);
    check("rst_din",    din_a, 8'h00);
    check("rst_wr_en",  wr_en_a, 1'b0);
    check("rst_stall",  stall_a, 1'b0);
    check("rst_ready",  ifa.req_ready, 4'b0000);

    // Single requester 0, three bytes, busy low.
    do_reset();
    s_len[0][0] = 3;
    s_byte[0][0][0] = 8'h41; s_byte[0][0][1] = 8'h42; s_byte[0][0][2] = 8'h43;
    s_last[0][0][2] = 1'b1;
    gchk_en = 1'b1; gchk_val = 4'b0001;
    drive();
    t0 = cyc;
    wait_wr(1'b0, 3, 1'b1, 200, "t1_count");
    if (wr_dat_a.size() == 3) begin
      check("t1_d0", wr_dat_a[0], 8'h41);
      check("t1_d1", wr_dat_a[1], 8'h42);
      check("t1_d2", wr_dat_a[2], 8'h43);
      check("t1_latency", wr_cyc_a[0] - t0, 2);
      check("t1_space01", wr_cyc_a[1] - wr_cyc_a[0], 16);
      check("t1_space12", wr_cyc_a[2] - wr_cyc_a[1], 16);
    end
    check("t1_grant_viol", grant_viol, 0);
    check("t1_active_end", active_a, 1'b0);

    // Three requesters, two 2-byte packets each: round-robin 0,1,2,0,1,2.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s_len[0][i] = 4;
      for (int p = 0; p < 4; p++) s_byte[0][i][p] = 8'h80 + 8'(16 * i + p);
      s_last[0][i][1] = 1'b1; s_last[0][i][3] = 1'b1;
    end
    exp_rr = '{8'h80, 8'h81, 8'h90, 8'h91, 8'hA0, 8'hA1,
               8'h82, 8'h83, 8'h92, 8'h93, 8'hA2, 8'hA3};
    drive();
    wait_wr(1'b0, 12, 1'b1, 800, "t2_count");
    if (wr_dat_a.size() == 12)
      for (int k = 0; k < 12; k++) check($sformatf("t2_byte%0d", k), wr_dat_a[k], exp_rr[k]);

    // Busy held for 100 cycles after the first byte.
    do_reset();
    s_len[0][0] = 2;
    s_byte[0][0][0] = 8'h55; s_byte[0][0][1] = 8'h66; s_last[0][0][1] = 1'b1;
    drive();
    wait_wr(1'b0, 1, 1'b0, 50, "t3_first");
    busy_a = 1'b1;
    repeat (100) cycle();
    busy_a = 1'b0;
    t0 = cyc;
    wait_wr(1'b0, 2, 1'b0, 50, "t3_count");
    check("t3_ready_viol", ready_viol, 0);
    if (wr_dat_a.size() == 2) begin
      check("t3_resume_cyc", wr_cyc_a[1] - t0, 1);
      check("t3_d1", wr_dat_a[1], 8'h66);
    end

    // Requester 1 stalls mid-packet; requester 2 is pending.
    do_reset();
    s_len[0][1] = 1; s_byte[0][1][0] = 8'h11;
    s_len[0][2] = 1; s_byte[0][2][0] = 8'h22; s_last[0][2][0] = 1'b1;
    drive();
    t0 = cyc;
    for (int c = 0; c < 1200 && stall_cyc_a.size() == 0; c++) cycle();
    check("t4_stall_seen", stall_cyc_a.size(), 1);
    if (stall_cyc_a.size() == 1) begin
      check("t4_stall_cyc", stall_cyc_a[0] - t0, 1025);
      check("t4_grant_at_stall", stall_grant_a, 4'b0000);
      check("t4_grant_next", grant_a, 4'b0100);
    end
    wait_wr(1'b0, 2, 1'b1, 50, "t4_count");
    if (wr_dat_a.size() == 2) check("t4_d1", wr_dat_a[1], 8'h22);
    check("t4_stall_once", stall_cyc_a.size(), 1);

    // Reset lands on the edge right after an accept: the strobe never appears.
    do_reset();
    s_len[0][0] = 3;
    s_byte[0][0][0] = 8'h71; s_byte[0][0][1] = 8'h72; s_byte[0][0][2] = 8'h73;
    s_last[0][0][2] = 1'b1;
    drive();
    cycle();
    rst = 1'b1;
    cycle();
    check("t5_accepted", acc_cnt_a, 1);
    check("t5_din",    din_a, 8'h00);
    check("t5_wr_en",  wr_en_a, 1'b0);
    check("t5_grant",  grant_a, 4'b0000);
    check("t5_active", active_a, 1'b0);
    check("t5_stall",  stall_a, 1'b0);
    check("t5_ready",  ifa.req_ready, 4'b0000);
    clear_sources();
    drive();
    rst = 1'b0;
    repeat (20) cycle();
    check("t5_no_strobe", wr_dat_a.size(), 0);

    // dut_b: requester 3 paused 3 cycles between bytes stays under STALL_MAX=4.
    do_reset();
    s_len[1][3] = 3; s_pause[1][3] = 3;
    s_byte[1][3][0] = 8'hC1; s_byte[1][3][1] = 8'hC2; s_byte[1][3][2] = 8'hC3;
    s_last[1][3][2] = 1'b1;
    drive();
    wait_wr(1'b1, 3, 1'b1, 100, "t6_count");
    check("t6_no_stall", stall_cyc_b.size(), 0);
    if (wr_dat_b.size() == 3) begin
      check("t6_d2", wr_dat_b[2], 8'hC3);
      check("t6_space", wr_cyc_b[1] - wr_cyc_b[0], 4);
    end
    check("t6_active_end", active_b, 1'b0);

    // dut_b: a 4-cycle pause reaches STALL_MAX; the packet then resumes under a new grant.
    do_reset();
    s_len[1][3] = 2; s_pause[1][3] = 4;
    s_byte[1][3][0] = 8'hD1; s_byte[1][3][1] = 8'hD2; s_last[1][3][1] = 1'b1;
    drive();
    wait_wr(1'b1, 2, 1'b1, 100, "t7_count");
    check("t7_stall_once", stall_cyc_b.size(), 1);
    if (stall_cyc_b.size() == 1 && wr_cyc_b.size() == 2) begin
      check("t7_stall_cyc", stall_cyc_b[0] - wr_cyc_b[0], 4);
      check("t7_d1", wr_dat_b[1], 8'hD2);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
